// File: rtl/iob_aclint.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iob_aclint                                                    |
// | Purpose  : RISC-V ACLINT (MTIMER + MSWI + SSWI) behind an IOb-native     |
// |            slave port. The runtime prescaler divides clk_i into mtime    |
// |            ticks. Per-hart interrupt lines drive hart mip inputs.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_i         in   clock                                               |
// |   rst_n_i       in   synchronous active-low reset                        |
// |   iob_avalid_i  in   request valid                                       |
// |   iob_addr_i    in   byte address, bits [1:0] ignored                    |
// |   iob_wdata_i   in   write data                                          |
// |   iob_wstrb_i   in   byte strobes, all zero = read                       |
// |   iob_rvalid_o  out  read data valid, one cycle after the read           |
// |   iob_rdata_o   out  read data                                           |
// |   iob_ready_o   out  request accepted (high every cycle out of reset)    |
// |   mtip_o        out  machine timer interrupt pending, one bit per hart   |
// |   msip_o        out  machine software interrupt pending, one per hart    |
// |   ssip_o        out  supervisor software interrupt pulse, one per hart   |
// +--------------------------------------------------------------------------+
module iob_aclint #(
  parameter int N_HARTS      = 1,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int MTIME_W      = 64,
  parameter int PRESCALE_W   = 16,
  parameter int PRESCALE_RST = 99,
  parameter int SSWI_EN      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  iob_avalid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic                  iob_rvalid_o,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  iob_ready_o,
  output logic [N_HARTS-1:0]    mtip_o,
  output logic [N_HARTS-1:0]    msip_o,
  output logic [N_HARTS-1:0]    ssip_o
);

  localparam logic [31:0] c_MSIP_BASE  = 32'h0000_0000;
  localparam logic [31:0] c_MTCMP_BASE = 32'h0000_4000;
  localparam logic [31:0] c_MTIME_LO   = 32'h0000_BFF8;
  localparam logic [31:0] c_MTIME_HI   = 32'h0000_BFFC;
  localparam logic [31:0] c_SSIP_BASE  = 32'h0000_C000;
  localparam logic [31:0] c_PRESCALE_A = 32'h0000_C800;
  localparam logic [31:0] c_CTRL_A     = 32'h0000_C804;

  // Byte-strobe merge of a new bus word into an existing register word.
  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                  r_ready;
  logic                  r_rvalid;
  logic [DATA_W-1:0]     r_rdata;
  logic [MTIME_W-1:0]    r_mtime;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_mtime_en;

  logic [31:0]           w_a;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_tick;
  logic [63:0]           w_mtime_ext;
  logic [DATA_W-1:0]     w_rdata;
  logic [DATA_W-1:0]     w_hart_rdata [N_HARTS];
  logic [N_HARTS-1:0]    w_mtip;
  logic [N_HARTS-1:0]    w_msip;
  logic [N_HARTS-1:0]    w_ssip;

  // Word-aligned, zero-extended address used by every decoder below.
  assign w_a         = 32'(iob_addr_i) & ~32'h3;
  assign w_wr        = iob_avalid_i & r_ready & (|iob_wstrb_i);
  assign w_rd        = iob_avalid_i & r_ready & ~(|iob_wstrb_i);
  assign w_tick      = r_mtime_en & (r_pcnt == r_prescale);
  assign w_mtime_ext = 64'(r_mtime);

  // Bus handshake and registered read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ready  <= 1'b1;
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  // Prescaler and control; a PRESCALE write restarts the count from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_prescale <= PRESCALE_W'(PRESCALE_RST);
      r_pcnt     <= '0;
      r_mtime_en <= 1'b1;
    end else begin
      if (w_wr && (w_a == c_PRESCALE_A)) begin
        r_prescale <= PRESCALE_W'(f_merge(DATA_W'(r_prescale), iob_wdata_i, iob_wstrb_i));
        r_pcnt     <= '0;
      end else if (r_mtime_en) begin
        r_pcnt <= (r_pcnt == r_prescale) ? '0 : r_pcnt + PRESCALE_W'(1);
      end
      if (w_wr && (w_a == c_CTRL_A) && iob_wstrb_i[0]) r_mtime_en <= iob_wdata_i[0];
    end
  end

  // mtime: a bus write to either half wins over a coincident tick, and the
  // untouched half keeps its old value (no carry from the dropped tick).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_mtime <= '0;
    end else if (w_wr && (w_a == c_MTIME_LO)) begin
      r_mtime <= MTIME_W'({w_mtime_ext[63:32],
                           f_merge(w_mtime_ext[31:0], iob_wdata_i, iob_wstrb_i)});
    end else if (w_wr && (w_a == c_MTIME_HI)) begin
      r_mtime <= MTIME_W'({f_merge(w_mtime_ext[63:32], iob_wdata_i, iob_wstrb_i),
                           w_mtime_ext[31:0]});
    end else if (w_tick) begin
      r_mtime <= r_mtime + MTIME_W'(1);
    end
  end

  // Per-hart registers: MSIP, MTIMECMP, registered mtip and optional SSWI.
  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    localparam logic [31:0] c_MSIP_A  = c_MSIP_BASE + 32'(4 * h);
    localparam logic [31:0] c_CMP_LO  = c_MTCMP_BASE + 32'(8 * h);
    localparam logic [31:0] c_CMP_HI  = c_MTCMP_BASE + 32'(8 * h + 4);

    logic               r_msip_h;
    logic               r_mtip_h;
    logic [MTIME_W-1:0] r_cmp_h;
    logic [63:0]        w_cmp_ext;
    logic               w_sel_msip;
    logic               w_sel_lo;
    logic               w_sel_hi;

    assign w_cmp_ext  = 64'(r_cmp_h);
    assign w_sel_msip = (w_a == c_MSIP_A);
    assign w_sel_lo   = (w_a == c_CMP_LO);
    assign w_sel_hi   = (w_a == c_CMP_HI);

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_msip_h <= 1'b0;
        r_mtip_h <= 1'b0;
        r_cmp_h  <= '1;
      end else begin
        if (w_wr && w_sel_msip && iob_wstrb_i[0]) r_msip_h <= iob_wdata_i[0];
        if (w_wr && w_sel_lo) begin
          r_cmp_h <= MTIME_W'({w_cmp_ext[63:32],
                               f_merge(w_cmp_ext[31:0], iob_wdata_i, iob_wstrb_i)});
        end else if (w_wr && w_sel_hi) begin
          r_cmp_h <= MTIME_W'({f_merge(w_cmp_ext[63:32], iob_wdata_i, iob_wstrb_i),
                               w_cmp_ext[31:0]});
        end
        // Level compare, registered: follows mtime/mtimecmp one cycle later.
        r_mtip_h <= (r_mtime >= r_cmp_h);
      end
    end

    assign w_msip[h] = r_msip_h;
    assign w_mtip[h] = r_mtip_h;
    assign w_hart_rdata[h] = w_sel_msip ? {31'b0, r_msip_h} :
                             w_sel_lo   ? w_cmp_ext[31:0]   :
                             w_sel_hi   ? w_cmp_ext[63:32]  : '0;

    if (SSWI_EN != 0) begin : g_sswi
      localparam logic [31:0] c_SSIP_A = c_SSIP_BASE + 32'(4 * h);
      logic r_ssip_h;
      // Single-cycle pulse on each qualifying SETSSIP write.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_ssip_h <= 1'b0;
        else          r_ssip_h <= w_wr && (w_a == c_SSIP_A) && iob_wstrb_i[0] && iob_wdata_i[0];
      end
      assign w_ssip[h] = r_ssip_h;
    end else begin : g_no_sswi
      assign w_ssip[h] = 1'b0;
    end
  end

  // Read mux: per-hart windows are mutually exclusive, so OR them together.
  always_comb begin
    w_rdata = '0;
    for (int h = 0; h < N_HARTS; h++) w_rdata = w_rdata | w_hart_rdata[h];
    if (w_a == c_MTIME_LO)   w_rdata = w_mtime_ext[31:0];
    if (w_a == c_MTIME_HI)   w_rdata = w_mtime_ext[63:32];
    if (w_a == c_PRESCALE_A) w_rdata = DATA_W'(r_prescale);
    if (w_a == c_CTRL_A)     w_rdata = {31'b0, r_mtime_en};
  end

  assign iob_ready_o  = r_ready;
  assign iob_rvalid_o = r_rvalid;
  assign iob_rdata_o  = r_rdata;
  assign mtip_o       = w_mtip;
  assign msip_o       = w_msip;
  assign ssip_o       = w_ssip;

endmodule
`default_nettype wire
